// File: rtl/cpu_defs_pkg.sv
// Shared pipeline definitions: bus widths, reset PC and the fetch FSM encoding.
package cpu_defs;

    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam int          BR_BUS_WD       = 33;
    localparam logic [31:0] RESET_PC        = 32'h1bfffffc;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_fetch.sv
// Fetch stage: owns the PC, keeps at most one fetch outstanding on the SRAM-like
// bus and hands fetched words to decode through a one-entry buffer.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 ds_allowin,
    input  logic [cpu_defs::BR_BUS_WD-1:0]       br_bus,
    output logic                                 fs_to_ds_valid,
    output logic [cpu_defs::FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                                 inst_sram_req,
    output logic                                 inst_sram_wr,
    output logic [1:0]                           inst_sram_size,
    output logic [3:0]                           inst_sram_wstrb,
    output logic [31:0]                          inst_sram_addr,
    output logic [31:0]                          inst_sram_wdata,
    input  logic                                 inst_sram_addr_ok,
    input  logic                                 inst_sram_data_ok,
    input  logic [31:0]                          inst_sram_rdata
);
    import cpu_defs::*;

    // state  | meaning
    // S_REQ  | presenting next_pc, waiting for addr_ok
    // S_WAIT | one fetch accepted, waiting for its data_ok

    fetch_state_e state;
    logic [31:0]  last_pc;
    logic [31:0]  redir_target;
    logic         redir_pend;
    logic         discard;

    logic         br_taken;
    logic [31:0]  br_target;
    logic         redir;
    logic [31:0]  next_pc;
    logic         accept;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // A taken branch only counts once decode can move; while stalled it may be stale.
    assign redir = br_taken && ds_allowin;

    assign next_pc = redir      ? br_target    :
                     redir_pend ? redir_target :
                                  last_pc + 32'd4;

    assign inst_sram_req   = !reset && (state == S_REQ) && (!fs_to_ds_valid || ds_allowin);
    assign inst_sram_addr  = next_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign accept = inst_sram_req && inst_sram_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_REQ;
            last_pc        <= RESET_PC;
            redir_pend     <= 1'b0;
            redir_target   <= 32'h0;
            discard        <= 1'b0;
            fs_to_ds_valid <= 1'b0;
            fs_to_ds_bus   <= '0;
        end else begin
            // A redirect that coincides with an accept still leaves the latch set,
            // because that accepted fetch is discarded and must be reissued.
            if (redir) begin
                redir_pend   <= 1'b1;
                redir_target <= br_target;
            end else if (accept) begin
                redir_pend   <= 1'b0;
            end

            if (fs_to_ds_valid && ds_allowin) begin
                fs_to_ds_valid <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    if (accept) begin
                        last_pc <= next_pc;
                        state   <= S_WAIT;
                        if (redir) begin
                            discard <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                        if (!discard && !redir) begin
                            fs_to_ds_valid <= 1'b1;
                            fs_to_ds_bus   <= {inst_sram_rdata, last_pc};
                        end
                    end else if (redir) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the fetch stage.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int total = 0;
    int bad   = 0;

    // memory responder: one slot, answers mem_dly cycles after the accept cycle + 1
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;
    int          mem_dly  = 0;

    // reference model: fetch history as transactions
    logic [31:0] m_last, m_ptgt, m_oaddr;
    logic        m_pend, m_out, m_kill, m_zero;
    logic [63:0] m_q[$];

    logic        obs_req;
    logic [31:0] obs_addr;

    if_stage_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_step();
        logic        redir, want_req, accept;
        logic [31:0] want_addr;
        redir     = br_bus[32] && ds_allowin;
        want_addr = redir ? br_bus[31:0] : (m_pend ? m_ptgt : m_last + 32'd4);
        want_req  = !reset && !m_out && (m_q.size() == 0 || ds_allowin);

        chk("req", {63'h0, inst_sram_req}, {63'h0, want_req});
        if (want_req) chk("addr", {32'h0, inst_sram_addr}, {32'h0, want_addr});
        chk("valid", {63'h0, fs_to_ds_valid}, {63'h0, m_q.size() != 0});
        if (m_q.size() != 0) chk("bus", fs_to_ds_bus, m_q[0]);
        else if (m_zero) chk("bus_reset", fs_to_ds_bus, 64'h0);
        chk("tied", {25'h0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
            {25'h0, 1'b0, 2'd2, 4'h0, 32'h0});

        if (reset) begin
            m_last = 32'h1bfffffc;
            m_pend = 1'b0;
            m_out  = 1'b0;
            m_kill = 1'b0;
            m_zero = 1'b1;
            m_q.delete();
        end else begin
            accept = want_req && inst_sram_addr_ok;
            if (m_q.size() != 0 && ds_allowin) void'(m_q.pop_front());
            if (m_out && inst_sram_data_ok) begin
                if (!m_kill && !redir) begin
                    m_q.push_back({inst_of(m_oaddr), m_oaddr});
                    m_zero = 1'b0;
                end
                m_out = 1'b0;
            end else if (m_out && redir) begin
                m_kill = 1'b1;
            end
            if (accept) begin
                m_out   = 1'b1;
                m_oaddr = want_addr;
                m_kill  = redir;
                m_last  = want_addr;
            end
            if (redir) begin
                m_pend = 1'b1;
                m_ptgt = br_bus[31:0];
            end else if (accept) begin
                m_pend = 1'b0;
            end
        end
    endtask

    // One clock: called just after a negedge with the stimulus already set.
    task automatic cyc();
        inst_sram_data_ok = mem_busy && (mem_cnt == 0);
        inst_sram_rdata   = inst_sram_data_ok ? inst_of(mem_addr) : $urandom();
        #1;
        obs_req  = inst_sram_req;
        obs_addr = inst_sram_addr;
        model_step();
        if (inst_sram_data_ok) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (obs_req && inst_sram_addr_ok) begin
            mem_busy = 1'b1;
            mem_addr = obs_addr;
            mem_cnt  = mem_dly;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        reset             = 1'b1;
        ds_allowin        = 1'b1;
        br_bus            = 33'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        m_last = 32'h1bfffffc;
        m_ptgt = 32'h0;
        m_oaddr = 32'h0;
        m_pend = 1'b0;
        m_out  = 1'b0;
        m_kill = 1'b0;
        m_zero = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // reset held, then first fetch with one-cycle data latency
        repeat (3) cyc();
        chk("rst_valid", {63'h0, fs_to_ds_valid}, 64'h0);
        chk("rst_bus", fs_to_ds_bus, 64'h0);
        reset = 1'b0;
        inst_sram_addr_ok = 1'b1;
        mem_dly = 0;
        cyc();
        chk("t1_req", {63'h0, obs_req}, 64'h1);
        chk("t1_addr0", {32'h0, obs_addr}, 64'h1c000000);
        cyc();
        chk("t1_wait_req", {63'h0, obs_req}, 64'h0);
        chk("t1_valid", {63'h0, fs_to_ds_valid}, 64'h1);
        chk("t1_bus", fs_to_ds_bus, {inst_of(32'h1c000000), 32'h1c000000});
        cyc();
        chk("t1_addr1", {32'h0, obs_addr}, 64'h1c000004);

        // decode stalled with an instruction buffered
        ds_allowin = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_req", {63'h0, obs_req}, 64'h0);
            chk("t2_valid", {63'h0, fs_to_ds_valid}, 64'h1);
            chk("t2_bus", fs_to_ds_bus, {inst_of(32'h1c000004), 32'h1c000004});
        end
        ds_allowin = 1'b1;
        mem_dly = 2;
        cyc();
        chk("t2_resume_req", {63'h0, obs_req}, 64'h1);
        chk("t2_resume_addr", {32'h0, obs_addr}, 64'h1c000008);

        // redirect while waiting for data
        br_bus = {1'b1, 32'h1c000100};
        cyc();
        br_bus = 33'h0;
        cyc();
        cyc();
        chk("t3_drop", {63'h0, fs_to_ds_valid}, 64'h0);
        mem_dly = 0;
        cyc();
        chk("t3_req", {63'h0, obs_req}, 64'h1);
        chk("t3_addr", {32'h0, obs_addr}, 64'h1c000100);

        // branch held while decode stalled, then effective with a new target
        ds_allowin = 1'b0;
        br_bus = {1'b1, 32'h1c000200};
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_stall_req", {63'h0, obs_req}, 64'h0);
        end
        chk("t4_buf", fs_to_ds_bus, {inst_of(32'h1c000100), 32'h1c000100});
        ds_allowin = 1'b1;
        br_bus = {1'b1, 32'h1c000300};
        cyc();
        chk("t4_addr", {32'h0, obs_addr}, 64'h1c000300);
        br_bus = 33'h0;
        cyc();
        chk("t4_drop", {63'h0, fs_to_ds_valid}, 64'h0);
        cyc();
        chk("t4_refetch_req", {63'h0, obs_req}, 64'h1);
        chk("t4_refetch", {32'h0, obs_addr}, 64'h1c000300);

        // redirect in the same cycle as data_ok
        br_bus = {1'b1, 32'h1c000400};
        cyc();
        br_bus = 33'h0;
        chk("t5_drop", {63'h0, fs_to_ds_valid}, 64'h0);
        mem_dly = 1;
        cyc();
        chk("t5_addr", {32'h0, obs_addr}, 64'h1c000400);

        // reset while waiting; stale data_ok arrives after reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_req", {63'h0, obs_req}, 64'h1);
        chk("t6_addr", {32'h0, obs_addr}, 64'h1c000000);
        chk("t6_valid", {63'h0, fs_to_ds_valid}, 64'h0);

        // random traffic, including redirects near the top of the address space
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0) || (reset && $urandom_range(0, 1) == 0);
            ds_allowin = $urandom_range(0, 3) != 0;
            inst_sram_addr_ok = $urandom_range(0, 2) != 0;
            mem_dly = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: tgt = 32'hfffffffc;
                    1: tgt = 32'hfffffff4;
                    default: tgt = $urandom() & 32'hfffffffc;
                endcase
                br_bus = {1'b1, tgt};
            end else begin
                br_bus = {1'b0, $urandom()};
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Fetch stage of the 5-stage LoongArch pipeline: owns the PC and issues instruction fetches on an SRAM-like req/addr_ok/data_ok interface.
- Produces the fs->ds handshake and bus that the decode stage consumes.
- Consumes the decode stage's br_bus to redirect fetch and discard wrong-path fetches.
- At most one fetch is outstanding at any time.

Parameters:
RESET_PC, 32'h1bfffffc, PC value held at reset; first fetch address is RESET_PC+4 (0x1c000000).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
ds_allowin  in  1  decode stage can accept an instruction this cycle.
br_bus  in  33  {br_taken[32], br_target[31:0]} from decode.
fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
fs_to_ds_bus  out  64  {inst[63:32], pc[31:0]}.
inst_sram_req  out  1  fetch request.
inst_sram_wr  out  1  tied 0.
inst_sram_size  out  2  tied 2'd2 (word).
inst_sram_wstrb  out  4  tied 0.
inst_sram_addr  out  32  fetch address, word aligned.
inst_sram_wdata  out  32  tied 0.
inst_sram_addr_ok  in  1  request accepted this cycle when req=1.
inst_sram_data_ok  in  1  read data valid for the oldest accepted request.
inst_sram_rdata  in  32  instruction word.

Behaviour:
- Reset values: req=0, fs_to_ds_valid=0, fs_to_ds_bus=0, pc register=RESET_PC, redirect pending=0, discard flag=0, FSM=S_REQ.
- Redirect event: redir = br_bus[32] && ds_allowin.
  - br_taken is ignored while ds_allowin=0, because the decode stage may still be stalled on operands.
- next_pc: br_target if redir this cycle; else the latched redirect target if one is pending; else last_issued_pc+4.
- Redirect latch: set on redir. Cleared when a request carrying that target receives addr_ok. A newer redir overwrites it.
- FSM states:
  - S_REQ: req=1 only when the fs buffer is empty or drains this cycle (fs_to_ds_valid && ds_allowin). addr=next_pc. On req && addr_ok: last_issued_pc<=addr, go to S_WAIT.
  - S_WAIT: req=0. On data_ok: if discard=1, drop the data, clear discard, go to S_REQ. Otherwise load the fs buffer {rdata, last_issued_pc}, set fs_to_ds_valid=1, go to S_REQ.
- Discard flag is set on redir in either of these cases:
  - FSM is in S_WAIT and data_ok is not arriving the same cycle.
  - FSM is in S_REQ and addr_ok is accepted the same cycle.
- If redir coincides with data_ok in S_WAIT, that data is wrong-path. Drop it and do not load the fs buffer.
- fs buffer (one entry):
  - fs_to_ds_valid clears on handover (valid && ds_allowin) unless refilled the same cycle.
  - On redir, any buffered instruction is handed over that cycle; decode squashes it.
  - Contents hold stable while valid && !ds_allowin.
- Latency:
  - addr_ok at cycle t with data_ok at t+1 gives fs_to_ds_valid at t+2.
  - Back-to-back sustains 1 instruction per 2 cycles minimum (single outstanding).
- Width rules: PC arithmetic is modulo 2^32. Wrap past 0xfffffffc continues at 0x0.
- Reset mid-operation: a pending data_ok after reset is ignored (FSM=S_REQ, not S_WAIT). The memory side is reset concurrently.

Decomposition:
- Shared package (cpu_defs):
  - FS_TO_DS_BUS_WD=64
  - BR_BUS_WD=33
  - RESET_PC
  - fetch FSM state encoding {S_REQ, S_WAIT}
- No sub-module required; the fs buffer and FSM fit in one module.

Test Plan:
1. Reset held 3 cycles, then released with addr_ok=1 and data_ok 1 cycle later -> first req addr 0x1c000000; fs_to_ds_bus={rdata,0x1c000000}, valid 2 cycles after accept; next req 0x1c000004.
2. ds_allowin=0 for 5 cycles with an instruction buffered -> fs_to_ds_valid stays 1, bus unchanged, req stays 0; it resumes the cycle ds_allowin rises.
3. br_bus={1,0x1c000100} with ds_allowin=1 while in S_WAIT -> following data_ok is dropped (no valid); next req addr 0x1c000100.
4. br_taken=1 with ds_allowin=0 for 3 cycles, then ds_allowin=1 -> no redirect until that cycle; then next req uses the br_target sampled in the ds_allowin cycle.
5. redir in the same cycle as data_ok -> data not forwarded; next req addr = br_target.
6. reset asserted in S_WAIT, with data_ok arriving the cycle after reset -> fs_to_ds_valid stays 0; first post-reset req addr 0x1c000000.
